scanline_fetch_ctrl: RTL and testbench
======================================

// Module: scanline_fetch_ctrl
// PURPOSE
//  Sequencer that fills the 20-entry scanline RAM with one line of BG tile-map indices.
//  On a start pulse it fetches the 20 visible tile numbers for line LY from VRAM over a req/ack port.
//  It writes each index into scanline RAM port A, entry 0..19, then pulses done.
//  Port B of the scanline RAM stays with the pixel pipeline; this block owns port A only.
// PARAMETERS
//  NUM_TILES   20   entries per line (160 px / 8)
//  RAM_AW      5    scanline RAM address width
//  VRAM_AW     16   VRAM address width (CPU address space)
// PORTS
//  clk          in   1   single system clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  start        in   1   1-cycle pulse: begin fetching a line; ignored unless IDLE
//  abort        in   1   synchronous cancel (LCD off / mode change); wins over all else
//  ly           in   8   current line number, latched on accepted start
//  scy          in   8   BG scroll Y, latched on accepted start
//  scx          in   8   BG scroll X, latched on accepted start
//  map_sel      in   1   0: map base 0x9800, 1: map base 0x9C00; latched on start
//  vram_req     out  1   read request; held with stable vram_addr until vram_ack
//  vram_addr    out  16  tile-map byte address
//  vram_ack     in   1   transfer completes in a cycle with vram_req=1 and vram_ack=1
//  vram_rdata   in   8   read data, valid in the ack cycle only
//  ram_wr_en    out  1   scanline RAM port A write enable
//  ram_addr     out  5   scanline RAM port A address (0..19)
//  ram_wr_data  out  8   scanline RAM port A write data
//  busy         out  1   high from the cycle after accepted start through last WRITE
//  done         out  1   1-cycle pulse after the 20th write
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, tile counter=0, all outputs 0, latched inputs 0.
//  States: IDLE -> REQ -> WRITE -> (REQ | DONE) -> IDLE.
//   IDLE : start=1 latches ly/scy/scx/map_sel, clears i=0 -> REQ.
//   REQ  : vram_req=1, vram_addr=addr(i). On vram_ack, capture vram_rdata -> WRITE; else stay.
//   WRITE: ram_wr_en=1, ram_addr=i, ram_wr_data=captured byte; i==NUM_TILES-1 -> DONE, else i++ -> REQ.
//   DONE : done=1 for exactly one cycle, busy=0 -> IDLE.
//  Address: row = (ly+scy) mod 256 >> 3 (5 bits); col = ((scx>>3)+i) mod 32 (wraps at map edge).
//   vram_addr = base + row*32 + col, where base = 0x9800 or 0x9C00.
//  Timing: min 2 cycles per tile. If start is at cycle 0 and acks are immediate,
//   REQ(tile0) is cycle 1, WRITE(tile19) is cycle 40, and done is high in cycle 41.
//  vram_req is registered and deasserts the cycle after the ack; vram_addr stays stable while req=1.
//  start while busy or in DONE: ignored (no restart, no error).
//  abort=1 in any state: next state IDLE, no write and no done pulse; partial RAM contents remain.
//   abort and start in the same cycle: abort wins and start is dropped.
//  Reset mid-line: immediate return to IDLE; any outstanding VRAM request is dropped (req low).
//  Changes to scroll or ly inputs during a fetch have no effect until the next start.
// STRUCTURE
//  Shared package scanline_pkg: NUM_TILES, BG_MAP0_BASE=16'h9800, BG_MAP1_BASE=16'h9C00,
//   MAP_W=32, fetch state enum (IDLE/REQ/WRITE/DONE).
//  One sub-module: tile_map_addr_gen (combinational: ly, scy, scx, map_sel, i -> vram_addr).
//  FSM, counter and data capture register live in scanline_fetch_ctrl.
//  The top level instantiates this block next to the scanline RAM.
// TESTING
//  1. rst_n=0 mid-REQ -> all outputs 0 at once; after release, no done until a new start.
//  2. ly=0, scy=0, scx=0, map_sel=0, ack always 1 -> addrs 0x9800..0x9813; done at cycle 41; RAM[i]=rdata(i).
//  3. scx=0xF8 (col 31), map_sel=1, ly=5, scy=4 -> row 1; first addr 0x9C3F, second 0x9C20 (wrap).
//  4. ly=0xF0, scy=0x20 -> row 2 (sum wraps); ack after 3 cycles per tile -> req/addr held stable; done at cycle 81.
//  5. start pulsed at tile 7 -> ignored; abort at tile 10 -> IDLE next cycle; no done; RAM[10..19] unchanged.
//  6. abort and start in the same IDLE cycle -> stays IDLE and busy stays 0.

Source files
------------

// File: rtl/scanline_pkg.sv
// Shared constants and types for the BG scanline tile-index fetcher.
package scanline_pkg;

    // Visible tiles per line (160 px / 8 px).
    localparam int unsigned NUM_TILES = 20;

    // BG tile-map bases in the CPU address space and the map width in tiles.
    localparam logic [15:0] BG_MAP0_BASE = 16'h9800;
    localparam logic [15:0] BG_MAP1_BASE = 16'h9C00;
    localparam int unsigned MAP_W        = 32;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWrite,
        StDone
    } fetch_state_e;

endpackage

// File: rtl/tile_map_addr_gen.sv
// Combinational tile-map address for one tile of the current BG line.
module tile_map_addr_gen
    import scanline_pkg::*;
(
    input  logic [7:0]  ly,
    input  logic [7:0]  scy,
    input  logic [7:0]  scx,
    input  logic        map_sel,
    input  logic [4:0]  tile_idx,
    output logic [15:0] vram_addr
);

    logic [7:0] line_y;
    logic [4:0] row;
    logic [4:0] col;

    // Row comes from the scrolled line; column wraps at the 32-tile map edge.
    always_comb begin
        line_y    = ly + scy;              // wraps mod 256
        row       = line_y[7:3];
        col       = scx[7:3] + tile_idx;   // wraps mod 32
        vram_addr = (map_sel ? BG_MAP1_BASE : BG_MAP0_BASE)
                  + 16'(row) * 16'(MAP_W) + 16'(col);
    end

endmodule

// File: rtl/scanline_fetch_ctrl.sv
// Fetches one line of BG tile indices from VRAM into scanline RAM port A.
module scanline_fetch_ctrl
    import scanline_pkg::*;
#(
    parameter int unsigned RAM_AW  = 5,
    parameter int unsigned VRAM_AW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [7:0]         ly,
    input  logic [7:0]         scy,
    input  logic [7:0]         scx,
    input  logic               map_sel,
    output logic               vram_req,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic               vram_ack,
    input  logic [7:0]         vram_rdata,
    output logic               ram_wr_en,
    output logic [RAM_AW-1:0]  ram_addr,
    output logic [7:0]         ram_wr_data,
    output logic               busy,
    output logic               done
);

    fetch_state_e      state_q, state_d;
    logic [RAM_AW-1:0] tile_q, tile_d;
    logic [7:0]        ly_q, ly_d;
    logic [7:0]        scy_q, scy_d;
    logic [7:0]        scx_q, scx_d;
    logic              map_sel_q, map_sel_d;
    logic [7:0]        data_q, data_d;
    logic [15:0]       addr_calc;

    tile_map_addr_gen u_addr_gen (
        .ly        (ly_q),
        .scy       (scy_q),
        .scx       (scx_q),
        .map_sel   (map_sel_q),
        .tile_idx  (tile_q),
        .vram_addr (addr_calc)
    );

    // State, tile counter, latched line parameters and captured tile byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tile_q    <= '0;
            ly_q      <= '0;
            scy_q     <= '0;
            scx_q     <= '0;
            map_sel_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            tile_q    <= tile_d;
            ly_q      <= ly_d;
            scy_q     <= scy_d;
            scx_q     <= scx_d;
            map_sel_q <= map_sel_d;
            data_q    <= data_d;
        end
    end

    // Next-state logic and state-decoded outputs; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        tile_d      = tile_q;
        ly_d        = ly_q;
        scy_d       = scy_q;
        scx_d       = scx_q;
        map_sel_d   = map_sel_q;
        data_d      = data_q;
        vram_req    = 1'b0;
        vram_addr   = '0;
        ram_wr_en   = 1'b0;
        ram_addr    = '0;
        ram_wr_data = '0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A start coinciding with abort is dropped, parameters untouched.
                if (start && !abort) begin
                    ly_d      = ly;
                    scy_d     = scy;
                    scx_d     = scx;
                    map_sel_d = map_sel;
                    tile_d    = '0;
                    state_d   = StReq;
                end
            end
            StReq: begin
                busy      = 1'b1;
                vram_req  = 1'b1;
                vram_addr = addr_calc;
                if (vram_ack) begin
                    data_d  = vram_rdata;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                busy        = 1'b1;
                ram_wr_en   = !abort;
                ram_addr    = tile_q;
                ram_wr_data = data_q;
                if (tile_q == RAM_AW'(NUM_TILES - 1)) begin
                    state_d = StDone;
                end else begin
                    tile_d  = tile_q + 1'b1;
                    state_d = StReq;
                end
            end
            StDone: begin
                done    = !abort;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d = StIdle;
        end
    end

endmodule

// File: tb/tb_scanline_fetch_ctrl.sv
// Randomized scoreboard bench for scanline_fetch_ctrl.
module tb_scanline_fetch_ctrl;

    localparam int NT = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  ly = '0;
    logic [7:0]  scy = '0;
    logic [7:0]  scx = '0;
    logic        map_sel = 1'b0;
    logic        vram_ack = 1'b0;
    logic [7:0]  vram_rdata = '0;
    logic        vram_req;
    logic [15:0] vram_addr;
    logic        ram_wr_en;
    logic [4:0]  ram_addr;
    logic [7:0]  ram_wr_data;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    scanline_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .ly          (ly),
        .scy         (scy),
        .scx         (scx),
        .map_sel     (map_sel),
        .vram_req    (vram_req),
        .vram_addr   (vram_addr),
        .vram_ack    (vram_ack),
        .vram_rdata  (vram_rdata),
        .ram_wr_en   (ram_wr_en),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .busy        (busy),
        .done        (done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    // Scoreboard: filled by stimulus, drained by the monitor.
    logic [15:0] exp_addr[$];
    logic [12:0] exp_wr[$];
    int          exp_done[$];
    int          busy_from = 0;
    int          busy_to = 0;
    logic        ram_check = 1'b0;
    logic [7:0]  ref_ram[NT];
    logic [7:0]  ram_model[NT];

    // VRAM responder state for the line in flight.
    int          k = 0;
    int          wt = 0;
    int          lat[NT];
    logic [7:0]  line_data[NT];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    endfunction

    // Monitor: samples 1 ns after the falling edge, once inputs have settled.
    initial begin
        foreach (ram_model[j]) ram_model[j] = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                chk("reset outputs a", {vram_req, vram_addr, ram_wr_en, busy, done}, '0);
                chk("reset outputs b", {ram_addr, ram_wr_data}, '0);
            end else begin
                if (vram_req) begin
                    if (exp_addr.size() == 0) chk("vram_req with nothing pending", 64'(vram_req), 0);
                    else begin
                        chk("vram_addr", vram_addr, exp_addr[0]);
                        if (vram_ack) void'(exp_addr.pop_front());
                    end
                end
                if (ram_wr_en) begin
                    if (exp_wr.size() == 0) chk("unexpected ram write", 64'(ram_wr_en), 0);
                    else begin
                        chk("ram write addr/data", {ram_addr, ram_wr_data}, exp_wr[0]);
                        void'(exp_wr.pop_front());
                    end
                    if (int'(ram_addr) < NT) ram_model[ram_addr] = ram_wr_data;
                end
                if (done) begin
                    if (exp_done.size() == 0) chk("unexpected done", 64'(done), 0);
                    else begin
                        chk("done cycle", 64'(cyc), 64'(exp_done[0]));
                        void'(exp_done.pop_front());
                    end
                end else if (exp_done.size() != 0 && cyc > exp_done[0]) begin
                    chk("done missing", 64'(done), 1);
                    void'(exp_done.pop_front());
                end
                chk("busy", 64'(busy), 64'(cyc >= busy_from && cyc < busy_to));
                if (ram_check) begin
                    foreach (ref_ram[j]) chk($sformatf("ram[%0d]", j), ram_model[j], ref_ram[j]);
                    chk("leftover expected tiles", 64'(exp_addr.size() + exp_wr.size()), 0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

    // One cycle: clear pulses and answer an outstanding VRAM request.
    task automatic tick();
        @(negedge clk);
        start      = 1'b0;
        abort      = 1'b0;
        vram_ack   = 1'b0;
        vram_rdata = 8'($urandom);
        if (rst_n && vram_req && k < NT) begin
            wt++;
            if (wt >= lat[k]) begin
                vram_ack   = 1'b1;
                vram_rdata = line_data[k];
                k++;
                wt = 0;
            end
        end
    endtask

    task automatic flush();
        exp_addr.delete();
        exp_wr.delete();
        exp_done.delete();
    endtask

    task automatic commit(input int n);
        for (int j = 0; j < n; j++) ref_ram[j] = line_data[j];
    endtask

    task automatic do_ram_check();
        tick();
        ram_check = 1'b1;
        tick();
        ram_check = 1'b0;
    endtask

    // Issue one line; fixed_lat=0 means random 1..3 REQ cycles per tile.
    task automatic run_line(input logic [7:0] l, input logic [7:0] y, input logic [7:0] x,
                            input logic ms, input int fixed_lat, input int restart_at,
                            input int abort_at, input int reset_at);
        int total;
        int row;
        int col;
        int base;
        int s;
        bit restarted = 1'b0;
        tick();
        ly      = l;
        scy     = y;
        scx     = x;
        map_sel = ms;
        start   = 1'b1;
        s       = cyc;
        row     = ((int'(l) + int'(y)) % 256) / 8;
        base    = ms ? 'h9C00 : 'h9800;
        total   = 1;
        k       = 0;
        wt      = 0;
        flush();
        for (int i = 0; i < NT; i++) begin
            col          = (int'(x) / 8 + i) % 32;
            lat[i]       = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
            line_data[i] = 8'($urandom);
            exp_addr.push_back(16'(base + row * 32 + col));
            exp_wr.push_back({5'(i), line_data[i]});
            total += lat[i] + 1;
        end
        exp_done.push_back(s + total);
        busy_from = s + 1;
        busy_to   = s + total;
        for (int n = 0; n < total + 2; n++) begin
            tick();
            // Line parameters must be latched; scramble them mid-fetch.
            ly      = 8'($urandom);
            scy     = 8'($urandom);
            scx     = 8'($urandom);
            map_sel = 1'($urandom);
            if (k == restart_at && !restarted) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            if (vram_req && !vram_ack && k == abort_at) begin
                abort   = 1'b1;
                busy_to = cyc + 1;
                tick();
                flush();
                commit(k);
                do_ram_check();
                return;
            end
            if (vram_req && !vram_ack && k == reset_at) begin
                rst_n   = 1'b0;
                busy_to = cyc;
                flush();
                commit(k);
                tick();
                tick();
                rst_n = 1'b1;
                repeat (6) tick();
                do_ram_check();
                return;
            end
        end
        commit(NT);
        do_ram_check();
    endtask

    initial begin
        foreach (ref_ram[j]) ref_ram[j] = '0;
        foreach (lat[j]) lat[j] = 1;
        foreach (line_data[j]) line_data[j] = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a REQ; no done may follow.
        run_line(8'h10, 8'h00, 8'h00, 1'b0, 2, -1, -1, 3);
        // Plain line, immediate acks: done 41 cycles after start.
        run_line(8'h00, 8'h00, 8'h00, 1'b0, 1, -1, -1, -1);
        // Column wrap at the map edge on the second map.
        run_line(8'h05, 8'h04, 8'hF8, 1'b1, 0, -1, -1, -1);
        // Line sum wraps; slow acks hold req/addr.
        run_line(8'hF0, 8'h20, 8'h13, 1'b0, 3, -1, -1, -1);
        // Start mid-line is ignored; abort at tile 10 keeps RAM[10..19].
        run_line(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 2, 7, 10, -1);

        // Abort and start together in IDLE: nothing happens.
        tick();
        start = 1'b1;
        abort = 1'b1;
        repeat (6) tick();

        for (int n = 0; n < 5; n++) begin
            run_line(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 0,
                     int'($urandom_range(0, NT - 1)), -1, -1);
        end
        repeat (3) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
